// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative multiply/divide controller owning the HI/LO pair.
// Optional feature: define MULDIV_FAST_MUL_EN for single-cycle multiplies.
`timescale 1ns/1ps

package muldiv_pkg;
    typedef enum logic [4:0] {
        Alu_Func_Addu,
        Alu_Func_Subu,
        Alu_Func_And,
        Alu_Func_Or,
        Alu_Func_Xor,
        Alu_Func_Slt,
        Alu_Func_Sltu,
        Alu_Func_Sll,
        Alu_Func_Srl,
        Alu_Func_Sra,
        Alu_Func_Muls,
        Alu_Func_Mulu,
        Alu_Func_Divs,
        Alu_Func_Divu,
        Alu_Func_Mfhi,
        Alu_Func_Mflo,
        Alu_Func_Mthi,
        Alu_Func_Mtlo
    } alu_func_t;
endpackage

module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             valid,
    input  alu_func_t        func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] result
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    typedef enum logic [1:0] {OP_MUL, OP_DIV, OP_DIV0, OP_FMUL} op_t;

    state_t state, state_next;
    op_t    op;

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [CW-1:0]      cnt;
    logic               sign_a, sign_b;

    logic               hilo_class, accept, is_mul, is_div, is_signed, start;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [WIDTH:0]     div_part, div_diff;
    logic [2*WIDTH-1:0] div_step;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign hilo_class = func inside {Alu_Func_Muls, Alu_Func_Mulu, Alu_Func_Divs, Alu_Func_Divu,
                                     Alu_Func_Mfhi, Alu_Func_Mflo, Alu_Func_Mthi, Alu_Func_Mtlo};
    assign busy      = (state != IDLE);
    assign stall     = valid & busy & hilo_class & ~flush;
    assign accept    = valid & ~busy & ~flush;
    assign is_mul    = (func == Alu_Func_Muls) || (func == Alu_Func_Mulu);
    assign is_div    = (func == Alu_Func_Divs) || (func == Alu_Func_Divu);
    assign is_signed = (func == Alu_Func_Muls) || (func == Alu_Func_Divs);
    assign start     = accept & (is_mul | is_div);

    assign a_neg = is_signed & a[WIDTH-1];
    assign b_neg = is_signed & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    always_comb begin
        result = '0;
        if (valid && func == Alu_Func_Mfhi) result = hi;
        if (valid && func == Alu_Func_Mflo) result = lo;
    end

    // Shift-add keeps the multiplier in the low half and shifts the partial product in from the top.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_step = {mul_sum, acc[WIDTH-1:1]};

    // Restoring divide: {remainder, dividend/quotient} shifts left one bit per iteration.
    assign div_part = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff = div_part - {1'b0, opnd};
    assign div_step = div_diff[WIDTH] ? {div_part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    assign mul_prod = (sign_a ^ sign_b) ? -acc : acc;

`ifdef MULDIV_FAST_MUL_EN
    logic               fast_signed;
    logic [2*WIDTH-1:0] fast_prod;

    always_comb begin
        if (fast_signed)
            fast_prod = $signed({{WIDTH{opnd[WIDTH-1]}}, opnd})
                      * $signed({{WIDTH{acc[WIDTH-1]}}, acc[WIDTH-1:0]});
        else
            fast_prod = {{WIDTH{1'b0}}, opnd} * {{WIDTH{1'b0}}, acc[WIDTH-1:0]};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)      fast_signed <= 1'b0;
        else if (start) fast_signed <= is_signed;
    end
`endif

    always_comb begin
        fix_hi = mul_prod[2*WIDTH-1:WIDTH];
        fix_lo = mul_prod[WIDTH-1:0];
        case (op)
            OP_DIV: begin
                fix_lo = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                fix_hi = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            end
            OP_DIV0: begin
                fix_lo = '1;
                fix_hi = acc[WIDTH-1:0];
            end
`ifdef MULDIV_FAST_MUL_EN
            OP_FMUL: begin
                fix_hi = fast_prod[2*WIDTH-1:WIDTH];
                fix_lo = fast_prod[WIDTH-1:0];
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (is_div && b == '0)
                        state_next = FIX;
`ifdef MULDIV_FAST_MUL_EN
                    else if (is_mul)
                        state_next = FIX;
`endif
                    else
                        state_next = RUN;
                end
            end
            RUN:     if (cnt == CW'(WIDTH - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi     <= '0;
            lo     <= '0;
            acc    <= '0;
            opnd   <= '0;
            cnt    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            op     <= OP_MUL;
        end else begin
            if (start) begin
                cnt    <= '0;
                sign_a <= a_neg;
                sign_b <= b_neg;
                if (is_div) begin
                    if (b == '0) begin
                        op  <= OP_DIV0;
                        acc <= {{WIDTH{1'b0}}, a};
                    end else begin
                        op   <= OP_DIV;
                        acc  <= {{WIDTH{1'b0}}, a_mag};
                        opnd <= b_mag;
                    end
                end else begin
`ifdef MULDIV_FAST_MUL_EN
                    op   <= OP_FMUL;
                    acc  <= {{WIDTH{1'b0}}, b};
                    opnd <= a;
`else
                    op   <= OP_MUL;
                    acc  <= {{WIDTH{1'b0}}, b_mag};
                    opnd <= a_mag;
`endif
                end
            end
            if (accept && func == Alu_Func_Mthi) hi <= a;
            if (accept && func == Alu_Func_Mtlo) lo <= a;
            if (state == RUN) begin
                cnt <= cnt + 1'b1;
                acc <= (op == OP_MUL) ? mul_step : div_step;
            end
            if (state == FIX && !flush) begin
                hi <= fix_hi;
                lo <= fix_lo;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (WIDTH = 32).
`timescale 1ns/1ps

module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int unsigned W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         valid;
    alu_func_t    func;
    logic [W-1:0] a, b;
    logic         flush;
    logic         stall, busy;
    logic [W-1:0] hi, lo, result;

    int n_assert = 0;
    int n_fail   = 0;
    int n;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clock  (clock),
        .reset  (reset),
        .valid  (valid),
        .func   (func),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .result (result)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        valid = 1'b0;
        flush = 1'b0;
        func  = Alu_Func_Addu;
        a     = '0;
        b     = '0;
    endtask

    task automatic issue(input alu_func_t f, input logic [W-1:0] av, input logic [W-1:0] bv);
        valid = 1'b1;
        flush = 1'b0;
        func  = f;
        a     = av;
        b     = bv;
    endtask

    // Counts cycles with busy high, giving up after 100.
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            step();
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_in();
        #12;
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_stall", {31'b0, stall}, 32'h0);
        check("reset_result", result, 32'h0);
        reset = 1'b0;
        step();

        issue(Alu_Func_Mthi, 32'h12345678, 32'h0);
        #1;
        check("mthi_stall", {31'b0, stall}, 32'h0);
        step();
        issue(Alu_Func_Mflo, 32'h0, 32'h0);
        #1;
        check("mthi_hi", hi, 32'h12345678);
        check("mflo_result_zero", result, 32'h0);
        step();

        issue(Alu_Func_Muls, 32'hFFFFFFFE, 32'h3);
        #1;
        check("muls_accept_stall", {31'b0, stall}, 32'h0);
        step();
        issue(Alu_Func_Mflo, 32'h0, 32'h0);
        #1;
        n = 0;
        while (stall && n < 100) begin
            n++;
            step();
        end
`ifdef MULDIV_FAST_MUL_EN
        check("muls_stall_cycles", n, 32'd1);
`else
        check("muls_stall_cycles", n, 32'd33);
`endif
        check("muls_mflo_result", result, 32'hFFFFFFFA);
        check("muls_hi", hi, 32'hFFFFFFFF);
        check("muls_busy_done", {31'b0, busy}, 32'h0);
        idle_in();
        step();

        issue(Alu_Func_Divs, 32'hFFFFFFF9, 32'h2);
        step();
        idle_in();
        count_busy(n);
        check("divs_busy_cycles", n, 32'd33);
        check("divs_lo", lo, 32'hFFFFFFFD);
        check("divs_hi", hi, 32'hFFFFFFFF);

        issue(Alu_Func_Divu, 32'h7, 32'h2);
        step();
        idle_in();
        count_busy(n);
        check("divu_busy_cycles", n, 32'd33);
        check("divu_lo", lo, 32'h3);
        check("divu_hi", hi, 32'h1);

        issue(Alu_Func_Divs, 32'h80000000, 32'hFFFFFFFF);
        step();
        idle_in();
        count_busy(n);
        check("divs_ovf_lo", lo, 32'h80000000);
        check("divs_ovf_hi", hi, 32'h0);

        issue(Alu_Func_Divu, 32'hDEADBEEF, 32'h0);
        step();
        idle_in();
        count_busy(n);
        check("div0_busy_cycles", n, 32'd1);
        check("div0_lo", lo, 32'hFFFFFFFF);
        check("div0_hi", hi, 32'hDEADBEEF);

`ifndef MULDIV_FAST_MUL_EN
        issue(Alu_Func_Mulu, 32'hFFFFFFFF, 32'hFFFFFFFF);
        step();
        for (int k = 1; k < 10; k++) begin
            issue((k == 5) ? Alu_Func_Mfhi : Alu_Func_Addu, 32'h1, 32'h2);
            #1;
            if (k == 5) check("busy_mfhi_stall", {31'b0, stall}, 32'h1);
            else        check("busy_addu_stall", {31'b0, stall}, 32'h0);
            step();
        end
        issue(Alu_Func_Mfhi, 32'h0, 32'h0);
        flush = 1'b1;
        #1;
        check("flush_valid_stall", {31'b0, stall}, 32'h0);
        check("flush_cycle_busy", {31'b0, busy}, 32'h1);
        step();
        idle_in();
        #1;
        check("flush_busy_next", {31'b0, busy}, 32'h0);
        check("flush_hi_kept", hi, 32'hDEADBEEF);
        check("flush_lo_kept", lo, 32'hFFFFFFFF);
        step();
`endif

        issue(Alu_Func_Mulu, 32'hFFFFFFFF, 32'hFFFFFFFF);
        step();
        issue(Alu_Func_Addu, 32'h5, 32'h6);
        #1;
        check("mulu_addu_stall", {31'b0, stall}, 32'h0);
        idle_in();
        count_busy(n);
`ifdef MULDIV_FAST_MUL_EN
        check("mulu_busy_cycles", n, 32'd1);
`else
        check("mulu_busy_cycles", n, 32'd33);
`endif
        check("mulu_hi", hi, 32'hFFFFFFFE);
        check("mulu_lo", lo, 32'h00000001);

        issue(Alu_Func_Mtlo, 32'hCAFEF00D, 32'h0);
        step();
        idle_in();
        #1;
        check("mtlo_lo", lo, 32'hCAFEF00D);
        check("mtlo_hi_kept", hi, 32'hFFFFFFFE);

        issue(Alu_Func_Divu, 32'd100, 32'd3);
        step();
        idle_in();
        step();
        step();
        step();
        step();
        check("div_t5_busy", {31'b0, busy}, 32'h1);
        reset = 1'b1;
        #1;
        check("async_reset_hi", hi, 32'h0);
        check("async_reset_lo", lo, 32'h0);
        check("async_reset_busy", {31'b0, busy}, 32'h0);
        step();
        reset = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
